// File: rtl/qv_pkg.sv
// Shared definitions for the dual-rail 4-valued signal encoding ({b1,b0} per net).
package qv_pkg;

  typedef logic [1:0] qv_t;

  localparam qv_t QV_0 = 2'b00;
  localparam qv_t QV_1 = 2'b01;
  localparam qv_t QV_X = 2'b10;
  localparam qv_t QV_Z = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FILL  = 1'b1
  } unpack_state_t;

  function automatic logic qv_is_known(input qv_t sym);
    return (sym == QV_0) || (sym == QV_1);
  endfunction

endpackage

// File: rtl/qv_sym_decode.sv
// Combinational decode of one dual-rail symbol into one-hot class flags.
module qv_sym_decode
  import qv_pkg::*;
(
  input  qv_t  sym,
  output logic is_one,
  output logic is_x,
  output logic is_z
);

  assign is_one = (sym == QV_1);
  assign is_x   = (sym == QV_X);
  assign is_z   = (sym == QV_Z);

endmodule

// File: rtl/qv_stream_unpacker.sv
// Packs a serial stream of dual-rail symbols into W-wide value / X-mask / Z-mask words.
module qv_stream_unpacker
  import qv_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_b1,
  input  logic             s_b0,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [W-1:0]     m_val,
  output logic [W-1:0]     m_xmask,
  output logic [W-1:0]     m_zmask,
  output logic [CNT_W-1:0] m_cnt,
  output logic             m_last,
  output logic             m_clean
);

  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

  unpack_state_t    state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next, wr_idx;
  logic [W-1:0]     acc_val_reg, acc_x_reg, acc_z_reg;
  logic [W-1:0]     word_val, word_x, word_z;
  logic             flag_reg;
  logic             m_valid_reg, m_last_reg, m_clean_reg;
  logic [W-1:0]     m_val_reg, m_xmask_reg, m_zmask_reg;
  logic [CNT_W-1:0] m_cnt_reg;
  logic             sym_is_one, sym_is_x, sym_is_z, sym_clean;
  logic             accept, emit;

  qv_sym_decode u_decode (
    .sym    ({s_b1, s_b0}),
    .is_one (sym_is_one),
    .is_x   (sym_is_x),
    .is_z   (sym_is_z)
  );

  assign sym_clean = !(sym_is_x || sym_is_z);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // Next-state logic: idx only wraps through an emit
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    if (accept) begin
      if (emit) begin
        state_next = ST_EMPTY;
        idx_next   = '0;
      end else begin
        state_next = ST_FILL;
        idx_next   = wr_idx + IDX_W'(1);
      end
    end
  end

  // Output / datapath decode
  always_comb begin
    s_ready = !m_valid_reg || m_ready;
    accept  = s_valid && s_ready;
    wr_idx  = (state_reg == ST_EMPTY) ? '0 : idx_reg;
    emit    = accept && ((wr_idx == IDX_W'(W - 1)) || s_last);
  end

  // Accumulator contents merged with the symbol currently on the input
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_merge
      assign word_val[gi] = (wr_idx == IDX_W'(gi)) ? sym_is_one : acc_val_reg[gi];
      assign word_x[gi]   = (wr_idx == IDX_W'(gi)) ? sym_is_x   : acc_x_reg[gi];
      assign word_z[gi]   = (wr_idx == IDX_W'(gi)) ? sym_is_z   : acc_z_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_val_reg <= '0;
      acc_x_reg   <= '0;
      acc_z_reg   <= '0;
      flag_reg    <= 1'b1;
      m_valid_reg <= 1'b0;
      m_val_reg   <= '0;
      m_xmask_reg <= '0;
      m_zmask_reg <= '0;
      m_cnt_reg   <= '0;
      m_last_reg  <= 1'b0;
      m_clean_reg <= 1'b1;
    end else begin
      if (accept) begin
        // Clearing on emit keeps unfilled bits of the next word at zero
        acc_val_reg <= emit ? '0 : word_val;
        acc_x_reg   <= emit ? '0 : word_x;
        acc_z_reg   <= emit ? '0 : word_z;
        flag_reg    <= (emit && s_last) ? 1'b1 : (flag_reg && sym_clean);
      end
      if (emit) begin
        m_valid_reg <= 1'b1;
        m_val_reg   <= word_val;
        m_xmask_reg <= word_x;
        m_zmask_reg <= word_z;
        m_cnt_reg   <= CNT_W'(wr_idx) + CNT_W'(1);
        m_last_reg  <= s_last;
        m_clean_reg <= s_last ? (flag_reg && sym_clean) : 1'b1;
      end else if (m_ready) begin
        m_valid_reg <= 1'b0;
      end
    end
  end

  assign m_valid = m_valid_reg;
  assign m_val   = m_val_reg;
  assign m_xmask = m_xmask_reg;
  assign m_zmask = m_zmask_reg;
  assign m_cnt   = m_cnt_reg;
  assign m_last  = m_last_reg;
  assign m_clean = m_clean_reg;

endmodule

// File: tb/tb_qv_stream_unpacker.sv
// Scoreboard bench for qv_stream_unpacker: a symbol-level model predicts each word.
module tb_qv_stream_unpacker;

  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_valid, s_ready, s_b1, s_b0, s_last;
  logic             m_valid, m_ready, m_last, m_clean;
  logic [W-1:0]     m_val, m_xmask, m_zmask;
  logic [CNT_W-1:0] m_cnt;

  qv_stream_unpacker #(.W(W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_b1    (s_b1),
    .s_b0    (s_b0),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_val   (m_val),
    .m_xmask (m_xmask),
    .m_zmask (m_zmask),
    .m_cnt   (m_cnt),
    .m_last  (m_last),
    .m_clean (m_clean)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]     val;
    logic [W-1:0]     xm;
    logic [W-1:0]     zm;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             clean;
  } exp_t;

  exp_t         exp_q[$];
  int           errors = 0;
  int           checks = 0;
  int           words_seen = 0;
  int           stall_cnt = 0;
  bit           rand_ready = 0;

  logic [W-1:0] mdl_val, mdl_x, mdl_z;
  int           mdl_idx;
  bit           mdl_flag;

  task automatic model_clear();
    mdl_val  = '0;
    mdl_x    = '0;
    mdl_z    = '0;
    mdl_idx  = 0;
    mdl_flag = 1'b1;
  endtask

  task automatic model_accept(input logic b1, input logic b0, input logic last);
    exp_t e;
    bit   is1, isx, isz;
    is1 = (b1 == 1'b0) && (b0 == 1'b1);
    isx = (b1 == 1'b1) && (b0 == 1'b0);
    isz = (b1 == 1'b1) && (b0 == 1'b1);
    mdl_val[mdl_idx] = is1;
    mdl_x[mdl_idx]   = isx;
    mdl_z[mdl_idx]   = isz;
    if (mdl_idx == W - 1 || last) begin
      e.val   = mdl_val;
      e.xm    = mdl_x;
      e.zm    = mdl_z;
      e.cnt   = CNT_W'(mdl_idx + 1);
      e.last  = last;
      e.clean = last ? (mdl_flag && !isx && !isz) : 1'b1;
      exp_q.push_back(e);
      mdl_flag = last ? 1'b1 : (mdl_flag && !isx && !isz);
      mdl_val = '0;
      mdl_x   = '0;
      mdl_z   = '0;
      mdl_idx = 0;
    end else begin
      mdl_flag = mdl_flag && !isx && !isz;
      mdl_idx++;
    end
  endtask

  // Monitor: every completed output handshake is compared with the oldest prediction
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && m_valid && m_ready) begin
      words_seen++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word: got val=%h cnt=%0d, required no word", m_val, m_cnt);
      end else begin
        e = exp_q.pop_front();
        checks += 6;
        if (m_val !== e.val) begin errors++; $display("FAIL word_val: got %h required %h", m_val, e.val); end
        if (m_xmask !== e.xm) begin errors++; $display("FAIL word_xmask: got %h required %h", m_xmask, e.xm); end
        if (m_zmask !== e.zm) begin errors++; $display("FAIL word_zmask: got %h required %h", m_zmask, e.zm); end
        if (m_cnt !== e.cnt) begin errors++; $display("FAIL word_cnt: got %0d required %0d", m_cnt, e.cnt); end
        if (m_last !== e.last) begin errors++; $display("FAIL word_last: got %b required %b", m_last, e.last); end
        if (m_clean !== e.clean) begin errors++; $display("FAIL word_clean: got %b required %b", m_clean, e.clean); end
        $display("word %0d: val=%h x=%h z=%h cnt=%0d last=%b clean=%b", words_seen, m_val, m_xmask, m_zmask, m_cnt, m_last, m_clean);
      end
    end
  end

  // Starts and ends at posedge+1 so all input changes stay clear of the sampling edge
  task automatic send_sym(input logic b1, input logic b0, input logic last);
    bit ok = 0;
    if (rand_ready) m_ready = ($urandom_range(0, 2) != 0);
    s_valid = 1'b1; s_b1 = b1; s_b0 = b0; s_last = last;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1; break; end
      stall_cnt++;
      @(posedge clk); #1;
      m_ready = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: s_ready stayed 0, required 1 within 50 cycles");
    end else begin
      @(posedge clk);
      model_accept(b1, b0, last);
      #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!m_valid && exp_q.size() == 0) begin done = 1; break; end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain: %0d words still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    checks += 2;
    if ({m_valid, m_val, m_xmask, m_zmask, m_cnt, m_last, m_clean} !==
        {1'b0, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL %s_outputs: got valid=%b val=%h x=%h z=%h cnt=%0d last=%b clean=%b, required 0/00/00/00/0/0/1",
               tag, m_valid, m_val, m_xmask, m_zmask, m_cnt, m_last, m_clean);
    end
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_s_ready: got %b required 1", tag, s_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_b1 = 1'b0; s_b0 = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_full_word();
    logic [15:0] syms;
    syms = 16'b01_00_01_01_10_11_00_01;
    for (int i = 0; i < 8; i++) send_sym(syms[15-2*i], syms[14-2*i], i == 7);
    wait_drain();
    $display("test_full_word done");
  endtask

  task automatic test_short_frame();
    send_sym(1'b0, 1'b1, 1'b0);
    send_sym(1'b0, 1'b1, 1'b0);
    send_sym(1'b0, 1'b0, 1'b1);
    wait_drain();
    $display("test_short_frame done");
  endtask

  task automatic test_back_to_back();
    int stalls0, words0;
    stalls0 = stall_cnt;
    words0  = words_seen;
    for (int i = 0; i < 16; i++) send_sym(1'b0, 1'(i % 3 == 0), i == 15);
    // Single-symbol frames: each emit coincides with the drain of the previous word
    for (int i = 0; i < 4; i++) send_sym(1'b0, 1'(i[0]), 1'b1);
    wait_drain();
    checks += 2;
    if (stall_cnt != stalls0) begin
      errors++;
      $display("FAIL b2b_stalls: got %0d stalls required 0", stall_cnt - stalls0);
    end
    if (words_seen - words0 != 6) begin
      errors++;
      $display("FAIL b2b_words: got %0d words required 6", words_seen - words0);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_hold();
    logic [W-1:0]     h_val, h_x, h_z;
    logic [CNT_W-1:0] h_cnt;
    logic             h_last, h_clean;
    m_ready = 1'b0;
    send_sym(1'b0, 1'b1, 1'b0);
    send_sym(1'b1, 1'b0, 1'b0);
    send_sym(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checks += 2;
    if (m_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b required 1", m_valid); end
    if (s_ready !== 1'b0) begin errors++; $display("FAIL hold_s_ready: got %b required 0", s_ready); end
    h_val = m_val; h_x = m_xmask; h_z = m_zmask; h_cnt = m_cnt; h_last = m_last; h_clean = m_clean;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks += 2;
      if ({m_valid, m_val, m_xmask, m_zmask, m_cnt, m_last, m_clean} !==
          {1'b1, h_val, h_x, h_z, h_cnt, h_last, h_clean}) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d got val=%h cnt=%0d valid=%b, required val=%h cnt=%0d valid=1",
                 i, m_val, m_cnt, m_valid, h_val, h_cnt);
      end
      if (s_ready !== 1'b0) begin errors++; $display("FAIL hold_s_ready_cycle: got %b required 0", s_ready); end
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL release_s_ready: got %b required 1", s_ready); end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL release_valid: got %b required 0", m_valid); end
    wait_drain();
    $display("test_hold done");
  endtask

  task automatic test_reset_mid_word();
    for (int i = 0; i < 5; i++) send_sym(1'b1, 1'(i[0]), 1'b0);
    rst_n = 1'b0;
    model_clear();
    exp_q.delete();
    @(negedge clk);
    check_reset_values("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send_sym(1'b0, 1'(i % 2 == 1), i == 7);
    wait_drain();
    $display("test_reset_mid_word done");
  endtask

  task automatic test_frame_clean();
    logic [15:0] a1;
    a1 = 16'b00_01_11_01_00_00_01_01;
    for (int i = 0; i < 8; i++) send_sym(a1[15-2*i], a1[14-2*i], 1'b0);
    send_sym(1'b0, 1'b1, 1'b0);
    send_sym(1'b0, 1'b0, 1'b0);
    send_sym(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) send_sym(1'b0, 1'(i != 2), i == 4);
    wait_drain();
    $display("test_frame_clean done");
  endtask

  task automatic test_random();
    logic [1:0] sym;
    rand_ready = 1;
    for (int i = 0; i < 80; i++) begin
      sym = 2'($urandom_range(0, 3));
      send_sym(sym[1], sym[0], ($urandom_range(0, 6) == 0) || (i == 79));
    end
    rand_ready = 0;
    wait_drain();
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_short_frame();
    test_back_to_back();
    test_hold();
    test_reset_mid_word();
    test_frame_clean();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qv_stream_unpacker.md
Name: qv_stream_unpacker

Overview:
- Receive end of the dual-rail 4-valued signal encoding used by the derived netlists. Every logical net is carried as a {_b1,_b0} pair.
- Accepts a serial stream of encoded symbols over a valid/ready handshake. Decodes each symbol and packs W symbols into a word of value, X-mask and Z-mask vectors.
- Sits between the simulator/trace side that serialises derived-netlist nets and the checker that compares decoded words against golden values.

Parameters:
- W, 8, symbols per output word (W >= 2).
- CNT_W, $clog2(W+1), width of the symbol-count output.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input symbol valid.
- s_ready  out  1  input symbol accepted when s_valid && s_ready.
- s_b1  in  1  encoded symbol, high rail.
- s_b0  in  1  encoded symbol, low rail.
- s_last  in  1  symbol is the last of its frame.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts the word.
- m_val  out  W  decoded logic values; bit i is the i-th symbol of the word.
- m_xmask  out  W  1 where the symbol decoded to X.
- m_zmask  out  W  1 where the symbol decoded to Z.
- m_cnt  out  CNT_W  number of valid symbols in the word (1..W).
- m_last  out  1  word closes a frame.
- m_clean  out  1  meaningful only with m_last: no X or Z anywhere in the frame.

Behaviour:
- Encoding {b1,b0} is fixed: 00 = logic 0, 01 = logic 1, 10 = X, 11 = Z.
- For an X or Z symbol, the m_val bit is 0.
- Reset (async assert, sync deassert handled upstream):
  - m_valid=0; m_val, m_xmask, m_zmask, m_cnt, m_last = 0; m_clean=1.
  - Accumulator empty, frame-clean flag = 1.
  - Any partial word or partial frame is discarded; reset mid-word leaves no residue.
- s_ready = !m_valid || m_ready, combinational from the registered m_valid plus m_ready. No dependency on s_valid.
- State machine:
  - EMPTY: idx = 0. An accepted symbol goes to FILL, or straight to a word emit if W reached or s_last.
  - FILL: 0 < idx < W. Each accepted symbol is written at bit idx, then idx++.
- Word emit: happens on the accepted symbol where idx+1 == W, or where s_last=1.
  - On that edge the output registers load the accumulator contents plus this symbol.
  - Unfilled bits are 0 in all three vectors.
  - m_cnt = idx+1; m_last = s_last; m_valid = 1; accumulator returns to EMPTY.
- Latency: the word is visible on m_* the cycle after its final symbol is accepted.
- Throughput: 1 symbol/cycle while m_ready is held high, including back-to-back words. The emit and the drain of the previous word may happen on the same edge.
- m_valid drops on m_valid && m_ready unless a new emit happens on the same edge.
- m_* are stable while m_valid && !m_ready.
- Frame-clean flag:
  - Cleared by any accepted X or Z symbol.
  - m_clean = flag AND (current symbol is 0/1), captured at an emit with s_last.
  - The flag returns to 1 after an s_last emit.
  - On non-last words m_clean = 1 and is ignored.
- s_last on the W-th symbol gives a single full word with m_last=1. It never produces an empty extra word.
- s_valid without s_ready: the symbol is held by the sender and nothing is sampled.
- idx wraps only via emit; idx never exceeds W-1.

Decomposition:
- Package qv_pkg holds:
  - Encoding localparams QV_0=2'b00, QV_1=2'b01, QV_X=2'b10, QV_Z=2'b11.
  - A qv_t 2-bit typedef.
- Sub-module qv_sym_decode: purely combinational, qv_t in, outputs is_one/is_x/is_z.
  - The same decode is reused by the checker.
- The unpacker instantiates qv_sym_decode once on {s_b1,s_b0}.

Test Plan:
- W=8, m_ready=1, send 8 symbols 01,00,01,01,10,11,00,01 with s_last on the 8th → one word, next cycle:
  - m_val=8'h8D, m_xmask=8'h10, m_zmask=8'h20, m_cnt=8, m_last=1, m_clean=0.
- Frame of 3 symbols 01,01,00 with s_last on the 3rd → m_val=8'h03, masks 0, m_cnt=3, m_last=1, m_clean=1.
- 16 clean symbols streamed with m_ready=1, s_last on the 16th:
  - s_ready never drops.
  - Two words on consecutive emit cycles: m_last=0 then 1; m_clean=1.
- Hold m_ready=0 after the first word:
  - s_ready=0 next cycle and m_* stable for 5 cycles.
  - Raise m_ready → word drains and s_ready=1 in the same cycle.
- Drop rst_n after 5 symbols of a word, then send 8 clean symbols with s_last → m_cnt=8, only the new data appears, m_clean=1.
- Frame A has a Z in word 1 and ends in word 2; frame B is clean → A's last word m_clean=0, B's last word m_clean=1.
